// File: rtl/dm_arbiter.sv
// dm_arbiter: shares the byte-lane data memory between port 0 (core) and port 1 (DMA/loader).
// Optional DM_ARB_STATS_EN adds per-port transfer counters and a starvation-force counter.
`ifndef DM_OP_BIT
`define DM_OP_BIT 3
`endif
`ifndef DM_ADDR_BIT
`define DM_ADDR_BIT 32
`endif

module dm_arbiter #(
    parameter int unsigned WAIT_MAX  = 4,
    parameter int unsigned BURST_MAX = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req0,
    input  logic [`DM_OP_BIT-1:0]   op0,
    input  logic                    w_en0,
    input  logic [`DM_ADDR_BIT-1:0] addr0,
    input  logic [31:0]             wdata0,
    output logic                    gnt0,
    output logic                    rvalid0,
    output logic [31:0]             rdata0,
    input  logic                    req1,
    input  logic [`DM_OP_BIT-1:0]   op1,
    input  logic                    w_en1,
    input  logic [`DM_ADDR_BIT-1:0] addr1,
    input  logic [31:0]             wdata1,
    output logic                    gnt1,
    output logic                    rvalid1,
    output logic [31:0]             rdata1,
    input  logic                    lock1,
    output logic                    dm_en,
    output logic [`DM_OP_BIT-1:0]   dm_op,
    output logic                    dm_w_en,
    output logic [`DM_ADDR_BIT-1:0] dm_addr,
    output logic [31:0]             dm_data_in,
`ifdef DM_ARB_STATS_EN
    output logic [15:0]             stat_gnt0,
    output logic [15:0]             stat_gnt1,
    output logic [7:0]              stat_force,
`endif
    input  logic [31:0]             dm_data
);

    localparam logic [3:0] WaitMax  = 4'(WAIT_MAX);
    localparam logic [7:0] BurstMax = 8'(BURST_MAX);

    typedef enum logic [0:0] {StArb, StBurst1} state_t;

    state_t      r_state, w_state_d;
    logic [3:0]  r_wait_cnt, w_wait_d;
    logic [7:0]  r_burst_cnt, w_burst_d, w_burst_inc;
    logic        w_gnt0, w_gnt1, w_force;
    logic        r_rvalid0, r_rvalid1;
    logic [31:0] r_rdata0, r_rdata1;

    assign w_burst_inc = r_burst_cnt + 8'd1;

    always_comb begin
        w_state_d = r_state;
        w_wait_d  = r_wait_cnt;
        w_burst_d = r_burst_cnt;
        w_gnt0    = 1'b0;
        w_gnt1    = 1'b0;
        w_force   = 1'b0;
        unique case (r_state)
            StArb: begin
                w_force = req1 && req0 && (r_wait_cnt == WaitMax);
                w_gnt1  = req1 && (!req0 || w_force);
                w_gnt0  = req0 && !w_gnt1;
                if (!req1 || w_gnt1) begin
                    w_wait_d = 4'd0;
                end else if (r_wait_cnt != WaitMax) begin
                    w_wait_d = r_wait_cnt + 4'd1;
                end
                // The entering grant counts as the first locked grant of the burst.
                if (w_gnt1 && lock1 && (BURST_MAX > 1)) begin
                    w_state_d = StBurst1;
                    w_burst_d = 8'd1;
                end
            end
            StBurst1: begin
                w_gnt1   = req1;
                w_wait_d = 4'd0;
                if (!lock1 || !req1 || (w_burst_inc == BurstMax)) begin
                    w_state_d = StArb;
                    w_burst_d = 8'd0;
                end else begin
                    w_burst_d = w_burst_inc;
                end
            end
            default: begin
                w_state_d = StArb;
            end
        endcase
        if (!rst_n) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end
    end

    always_comb begin
        dm_en      = 1'b0;
        dm_w_en    = 1'b0;
        dm_op      = '0;
        dm_addr    = '0;
        dm_data_in = '0;
        if (w_gnt0) begin
            dm_en      = 1'b1;
            dm_w_en    = w_en0;
            dm_op      = op0;
            dm_addr    = addr0;
            dm_data_in = wdata0;
        end else if (w_gnt1) begin
            dm_en      = 1'b1;
            dm_w_en    = w_en1;
            dm_op      = op1;
            dm_addr    = addr1;
            dm_data_in = wdata1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StArb;
            r_wait_cnt  <= 4'd0;
            r_burst_cnt <= 8'd0;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_rdata0    <= 32'd0;
            r_rdata1    <= 32'd0;
        end else begin
            r_state     <= w_state_d;
            r_wait_cnt  <= w_wait_d;
            r_burst_cnt <= w_burst_d;
            r_rvalid0   <= w_gnt0 && !w_en0;
            r_rvalid1   <= w_gnt1 && !w_en1;
            if (w_gnt0 && !w_en0) r_rdata0 <= dm_data;
            if (w_gnt1 && !w_en1) r_rdata1 <= dm_data;
        end
    end

`ifdef DM_ARB_STATS_EN
    logic [15:0] r_stat_gnt0, r_stat_gnt1;
    logic [7:0]  r_stat_force;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_gnt0  <= 16'd0;
            r_stat_gnt1  <= 16'd0;
            r_stat_force <= 8'd0;
        end else begin
            if (w_gnt0) r_stat_gnt0 <= r_stat_gnt0 + 16'd1;
            if (w_gnt1) r_stat_gnt1 <= r_stat_gnt1 + 16'd1;
            if (w_force && (r_stat_force != 8'hFF)) r_stat_force <= r_stat_force + 8'd1;
        end
    end

    assign stat_gnt0  = r_stat_gnt0;
    assign stat_gnt1  = r_stat_gnt1;
    assign stat_force = r_stat_force;
`endif

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a byte-lane memory model.
`ifndef DM_OP_BIT
`define DM_OP_BIT 3
`endif
`ifndef DM_ADDR_BIT
`define DM_ADDR_BIT 32
`endif

module tb_dm_arbiter;

    localparam logic [`DM_OP_BIT-1:0] OpWd = 0;
    localparam logic [`DM_OP_BIT-1:0] OpUh = 1;
    localparam logic [`DM_OP_BIT-1:0] OpUb = 2;
    localparam logic [`DM_OP_BIT-1:0] OpSh = 3;
    localparam logic [`DM_OP_BIT-1:0] OpSb = 4;

    logic                    clk, rst_n;
    logic                    req0, w_en0, gnt0, rvalid0;
    logic [`DM_OP_BIT-1:0]   op0;
    logic [`DM_ADDR_BIT-1:0] addr0;
    logic [31:0]             wdata0, rdata0;
    logic                    req1, w_en1, gnt1, rvalid1, lock1;
    logic [`DM_OP_BIT-1:0]   op1;
    logic [`DM_ADDR_BIT-1:0] addr1;
    logic [31:0]             wdata1, rdata1;
    logic                    dm_en, dm_w_en;
    logic [`DM_OP_BIT-1:0]   dm_op;
    logic [`DM_ADDR_BIT-1:0] dm_addr;
    logic [31:0]             dm_data_in, dm_data;
`ifdef DM_ARB_STATS_EN
    logic [15:0]             stat_gnt0, stat_gnt1;
    logic [7:0]              stat_force;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    dm_arbiter #(.WAIT_MAX(4), .BURST_MAX(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .op0(op0), .w_en0(w_en0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .op1(op1), .w_en1(w_en1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .lock1(lock1),
        .dm_en(dm_en), .dm_op(dm_op), .dm_w_en(dm_w_en), .dm_addr(dm_addr),
        .dm_data_in(dm_data_in),
`ifdef DM_ARB_STATS_EN
        .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_force(stat_force),
`endif
        .dm_data(dm_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Little-endian byte memory: combinational read, write on negedge.
    logic [7:0] mem [0:255];
    logic [7:0] ra, b0, b1, b2, b3;

    always_comb begin
        ra = dm_addr[7:0];
        b0 = mem[ra];
        b1 = mem[ra + 8'd1];
        b2 = mem[ra + 8'd2];
        b3 = mem[ra + 8'd3];
        dm_data = 32'd0;
        case (dm_op)
            OpWd:    dm_data = {b3, b2, b1, b0};
            OpUh:    dm_data = {16'd0, b1, b0};
            OpUb:    dm_data = {24'd0, b0};
            OpSh:    dm_data = {{16{b1[7]}}, b1, b0};
            OpSb:    dm_data = {{24{b0[7]}}, b0};
            default: dm_data = 32'd0;
        endcase
    end

    always @(negedge clk) begin
        if (dm_en && dm_w_en) begin
            mem[dm_addr[7:0]] <= dm_data_in[7:0];
            if (dm_op == OpWd || dm_op == OpUh || dm_op == OpSh)
                mem[dm_addr[7:0] + 8'd1] <= dm_data_in[15:8];
            if (dm_op == OpWd) begin
                mem[dm_addr[7:0] + 8'd2] <= dm_data_in[23:16];
                mem[dm_addr[7:0] + 8'd3] <= dm_data_in[31:24];
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_p0(input logic req, input logic we, input logic [`DM_OP_BIT-1:0] op,
                          input logic [`DM_ADDR_BIT-1:0] addr, input logic [31:0] data);
        req0 = req; w_en0 = we; op0 = op; addr0 = addr; wdata0 = data;
    endtask

    task automatic set_p1(input logic req, input logic lk, input logic we,
                          input logic [`DM_OP_BIT-1:0] op,
                          input logic [`DM_ADDR_BIT-1:0] addr, input logic [31:0] data);
        req1 = req; lock1 = lk; w_en1 = we; op1 = op; addr1 = addr; wdata1 = data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int k;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'd0;
        rst_n = 1'b0;
        set_p0(1'b1, 1'b0, OpWd, 32'h0, 32'h0);
        set_p1(1'b1, 1'b0, 1'b1, OpWd, 32'h0, 32'h0);
        #12;
        check_eq("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        check_eq("rst_dm_en", {30'd0, dm_en, dm_w_en}, 32'd0);
        check_eq("rst_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
        check_eq("rst_rdata0", rdata0, 32'd0);
        check_eq("rst_rdata1", rdata1, 32'd0);
        set_p0(1'b0, 1'b0, OpWd, 32'h0, 32'h0);
        set_p1(1'b0, 1'b0, 1'b0, OpWd, 32'h0, 32'h0);
        step();
        rst_n = 1'b1;
        step();

        // Port 0 write then read back.
        set_p0(1'b1, 1'b1, OpWd, 32'h10, 32'hDEADBEEF);
        #5;
        check_eq("p0_wr_gnt", {30'd0, gnt1, gnt0}, 32'd1);
        check_eq("p0_wr_dm", {30'd0, dm_en, dm_w_en}, 32'd3);
        check_eq("p0_wr_addr", dm_addr, 32'h10);
        check_eq("p0_wr_data", dm_data_in, 32'hDEADBEEF);
        step();
        set_p0(1'b1, 1'b0, OpWd, 32'h10, 32'h0);
        check_eq("p0_wr_no_rvalid", {31'd0, rvalid0}, 32'd0);
        #5;
        check_eq("p0_rd_gnt", {30'd0, gnt1, gnt0}, 32'd1);
        step();
        set_p0(1'b0, 1'b0, OpWd, 32'h0, 32'h0);
        check_eq("p0_rvalid", {31'd0, rvalid0}, 32'd1);
        check_eq("p0_rdata", rdata0, 32'hDEADBEEF);
        step();
        check_eq("p0_rvalid_pulse", {31'd0, rvalid0}, 32'd0);

        // Starvation guard: port 1 forced ahead at cycles 4 and 9.
        set_p0(1'b1, 1'b0, OpWd, 32'h0, 32'h0);
        set_p1(1'b1, 1'b0, 1'b0, OpWd, 32'h20, 32'h0);
        for (int c = 0; c < 10; c++) begin
            #5;
            check_eq($sformatf("starve_c%0d", c), {30'd0, gnt1, gnt0},
                     (c == 4 || c == 9) ? 32'd2 : 32'd1);
            step();
        end
        set_p0(1'b0, 1'b0, OpWd, 32'h0, 32'h0);
        set_p1(1'b0, 1'b0, 1'b0, OpWd, 32'h0, 32'h0);
        step();

        // Locked burst: 8 grants to port 1, one to port 0, then port 1 resumes.
        k = 0;
        for (int c = 0; c < 13; c++) begin
            set_p0((c >= 1 && c <= 8), 1'b0, OpWd, 32'h0, 32'h0);
            set_p1(1'b1, 1'b1, 1'b1, OpSb, 32'h40 + k, k);
            #5;
            check_eq($sformatf("burst_c%0d", c), {30'd0, gnt1, gnt0},
                     (c == 8) ? 32'd1 : 32'd2);
            step();
            if (c != 8) k++;
        end
        set_p0(1'b0, 1'b0, OpWd, 32'h0, 32'h0);
        set_p1(1'b0, 1'b0, 1'b0, OpWd, 32'h0, 32'h0);
        step();
        check_eq("burst_mem40", {24'd0, mem[8'h40]}, 32'h00);
        check_eq("burst_mem47", {24'd0, mem[8'h47]}, 32'h07);
        check_eq("burst_mem48", {24'd0, mem[8'h48]}, 32'h08);
        check_eq("burst_mem4b", {24'd0, mem[8'h4B]}, 32'h0B);

        // Port 1 sub-word reads with zero and sign extension.
        set_p1(1'b1, 1'b0, 1'b1, OpWd, 32'h10, 32'h80FF00AA);
        #5;
        check_eq("p1_wr_gnt", {30'd0, gnt1, gnt0}, 32'd2);
        step();
        set_p1(1'b1, 1'b0, 1'b0, OpUb, 32'h13, 32'h0);
        #5;
        check_eq("p1_ub_addr", dm_addr, 32'h13);
        step();
        check_eq("p1_ub_rvalid", {31'd0, rvalid1}, 32'd1);
        check_eq("p1_ub_rdata", rdata1, 32'h00000080);
        set_p1(1'b1, 1'b0, 1'b0, OpSb, 32'h13, 32'h0);
        step();
        set_p1(1'b0, 1'b0, 1'b0, OpWd, 32'h0, 32'h0);
        check_eq("p1_sb_rvalid", {31'd0, rvalid1}, 32'd1);
        check_eq("p1_sb_rdata", rdata1, 32'hFFFFFF80);
        step();
        check_eq("p1_rvalid_pulse", {31'd0, rvalid1}, 32'd0);

        // Reset asserted mid-burst with burst count at 3.
        set_p1(1'b1, 1'b1, 1'b0, OpUb, 32'h13, 32'h0);
        step();
        step();
        step();
        set_p0(1'b1, 1'b0, OpWd, 32'h10, 32'h0);
        #2;
        check_eq("pre_rst_gnt", {30'd0, gnt1, gnt0}, 32'd2);
        check_eq("pre_rst_rvalid1", {31'd0, rvalid1}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        check_eq("midrst_dm_en", {31'd0, dm_en}, 32'd0);
        check_eq("midrst_rvalid1", {31'd0, rvalid1}, 32'd0);
        step();
        check_eq("inrst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        rst_n = 1'b1;
        #4;
        check_eq("postrst_gnt", {30'd0, gnt1, gnt0}, 32'd1);
        step();
        set_p0(1'b0, 1'b0, OpWd, 32'h0, 32'h0);
        set_p1(1'b0, 1'b0, 1'b0, OpWd, 32'h0, 32'h0);
        check_eq("postrst_rvalid0", {31'd0, rvalid0}, 32'd1);
        check_eq("postrst_rdata0", rdata0, 32'h80FF00AA);

        // Idle: nothing driven to memory, no read strobes.
        for (int c = 0; c < 10; c++) begin
            step();
            #4;
            check_eq($sformatf("idle_c%0d", c), {28'd0, dm_en, dm_w_en, rvalid0, rvalid1},
                     32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
Two-port arbiter that shares the single byte-lane data memory between the core MEM stage (port 0) and the DMA/debug loader (port 1).
- Per port: req/gnt handshake; drives the memory's en/op/w_en/addr/data_in for the granted port.
- Returns read data one cycle later with a valid strobe.
- Port 0 has priority, with starvation protection for port 1. Port 1 may lock the memory for bounded bursts.

Parameters:
WAIT_MAX, 4, cycles port 1 may be denied before it is forced ahead of port 0 (1..15)
BURST_MAX, 8, maximum consecutive locked grants to port 1 (1..255)

Ports:
clk  in  1  system clock; all state updates on posedge
rst_n  in  1  asynchronous active-low reset
req0  in  1  port 0 access request
op0  in  `DM_OP_BIT  port 0 access op (WD/UH/UB/SH/SB)
w_en0  in  1  port 0 write
addr0  in  `DM_ADDR_BIT  port 0 byte address
wdata0  in  32  port 0 write data
gnt0  out  1  port 0 granted this cycle (combinational)
rvalid0  out  1  port 0 read data valid (registered)
rdata0  out  32  port 0 read data (registered)
req1, op1, w_en1, addr1, wdata1, gnt1, rvalid1, rdata1  as port 0, for port 1
lock1  in  1  port 1 requests burst lock
dm_en  out  1  memory enable
dm_op  out  `DM_OP_BIT  memory op
dm_w_en  out  1  memory write enable
dm_addr  out  `DM_ADDR_BIT  memory address
dm_data_in  out  32  memory write data
dm_data  in  32  memory combinational read data

Behaviour:
- Reset (rst_n low, async):
  - state=ARB; wait_cnt=0; burst_cnt=0.
  - rvalid0/1=0; rdata0/1=0.
  - gnt0/1, dm_en, dm_w_en forced 0 while rst_n low.
- Transfer completes at a posedge with req&&gnt. Requester holds op/addr/wdata/w_en stable until then.
- Memory reads combinationally and writes on negedge, so every granted access takes exactly one cycle.
- Mux:
  - Granted port's fields drive dm_*; dm_en=1.
  - No grant: dm_en=0, dm_w_en=0, dm_op/dm_addr/dm_data_in=0.
- Read return: on completed access with w_en=0, rdataN<=dm_data and rvalidN<=1 next cycle. Otherwise rvalidN<=0 (single-cycle pulse). Writes produce no rvalid.
- FSM state ARB:
  - gnt1 = req1 && (!req0 || wait_cnt==WAIT_MAX).
  - gnt0 = req0 && !gnt1.
  - wait_cnt: +1 (saturating at WAIT_MAX) when req1&&!gnt1. Cleared on gnt1 or !req1.
  - gnt1&&lock1 -> BURST1, burst_cnt<=1.
- FSM state BURST1:
  - gnt1=req1; gnt0=0; wait_cnt held at 0.
  - On each grant, burst_cnt+1.
  - Exit to ARB when !lock1, !req1, or a grant occurs with burst_cnt==BURST_MAX; clear burst_cnt on exit.
  - After a BURST_MAX exit, the first ARB cycle grants port 0 if req0, regardless of lock1.
- Simultaneous req0&&req1 with wait_cnt<WAIT_MAX: port 0 wins.
- WAIT_MAX reached: port 1 wins exactly once, then wait_cnt=0.
- Reset mid-burst: state returns to ARB, no pending rvalid; the aborted cycle's write is not guaranteed.
- No write/read reorder: grants are strictly serialized.

Optional Feature:
DM_ARB_STATS_EN
- Defined:
  - Adds outputs stat_gnt0[15:0] and stat_gnt1[15:0]: wrapping counts of completed transfers per port.
  - Adds output stat_force[7:0]: saturating count of starvation-forced grants.
  - All counters reset to 0.
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Port 0 WD write 0xDEADBEEF @0x10, then port 0 read WD @0x10 -> gnt0 both cycles; rvalid0 pulse one cycle after read; rdata0=0xDEADBEEF.
- req0 held high continuously, req1 high from cycle 0 -> gnt1 exactly at cycle WAIT_MAX (4), gnt0 all other cycles; wait_cnt returns to 0.
- Port 1 lock1=1 with 12 back-to-back SB writes, req0 high -> 8 consecutive gnt1, then one gnt0, then port 1 resumes.
- Port 1 UB read @0x13 after WD write 0x80FF00AA @0x10 -> rdata1=0x00000080; SB read -> 0xFFFFFF80.
- rst_n pulsed low mid-burst (burst_cnt=3) -> gnt/rvalid/dm_en drop immediately; after release state=ARB and req0 granted first cycle.
- No requests for 10 cycles -> dm_en=0, dm_w_en=0, rvalid0/1=0 throughout.
